// File: rtl/flash_arb_pkg.sv
// Shared constants and state type for the dual-port SPI flash read arbiter.
package flash_arb_pkg;
  localparam logic [7:0] FLASH_CMD_READ = 8'h03;
  localparam int XFER_BITS = 64;
  localparam int DATA_BITS = 32;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} arb_state_e;
endpackage

// File: rtl/flash_read_arbiter_if.sv
// Two read-requester ports (instruction fetch = 0, data load = 1) into the flash arbiter.
interface flash_read_arbiter_if #(parameter int ADDR_BITS = 24);
  import flash_arb_pkg::*;

  logic                 req0;
  logic [ADDR_BITS-1:0] addr0;
  logic                 ack0;
  logic [DATA_BITS-1:0] rdata0;
  logic                 req1;
  logic [ADDR_BITS-1:0] addr1;
  logic                 ack1;
  logic [DATA_BITS-1:0] rdata1;

  modport master (output req0, addr0, req1, addr1,
                  input  ack0, rdata0, ack1, rdata1);
  modport slave  (input  req0, addr0, req1, addr1,
                  output ack0, rdata0, ack1, rdata1);
endinterface

// File: rtl/spi_shifter.sv
// Mode-0 SPI bit engine: SCK divider, 64-bit MSB-first output frame, data-phase capture.
module spi_shifter
  import flash_arb_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [XFER_BITS-1:0] load_frame,
  input  logic                 run,
  input  logic                 miso,
  output logic                 sck,
  output logic                 mosi,
  output logic                 done,
  output logic [DATA_BITS-1:0] rx_word
);
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(XFER_BITS);
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]     div_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [XFER_BITS-1:0] shift_out;
  logic [DATA_BITS-1:0] shift_in;
  logic                 sck_rose;
  logic                 toggle;

  assign toggle = run && (div_cnt == '0);
  assign done   = toggle && sck && (bit_cnt == '0);
  assign mosi   = shift_out[XFER_BITS-1];
  // Include the bit being captured this cycle so the word is complete when done fires with CLK_DIV=1.
  assign rx_word = sck_rose ? {shift_in[DATA_BITS-2:0], miso} : shift_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shift_out <= '0;
      shift_in  <= '0;
      sck       <= 1'b0;
      sck_rose  <= 1'b0;
    end else if (load) begin
      div_cnt   <= DIV_RELOAD;
      bit_cnt   <= BIT_W'(XFER_BITS - 1);
      shift_out <= load_frame;
      shift_in  <= '0;
      sck       <= 1'b0;
      sck_rose  <= 1'b0;
    end else if (run) begin
      sck_rose <= 1'b0;
      // Only the last 32 captured bits (the data phase) are kept.
      if (sck_rose) shift_in <= {shift_in[DATA_BITS-2:0], miso};
      if (toggle) begin
        div_cnt <= DIV_RELOAD;
        sck     <= ~sck;
        if (!sck) begin
          sck_rose <= 1'b1;
        end else begin
          shift_out <= {shift_out[XFER_BITS-2:0], 1'b0};
          if (bit_cnt != '0) bit_cnt <= bit_cnt - 1'b1;
        end
      end else begin
        div_cnt <= div_cnt - 1'b1;
      end
    end
  end
endmodule

// File: rtl/flash_read_arbiter.sv
// Round-robin arbiter sharing one SPI flash between fetch and load ports, one READ (0x03) per word.
//   state | meaning
//   IDLE  | csb high, waiting for a request; grant taken here only
//   SHIFT | csb low, 64-bit command/address/data frame on the wire
//   GAP   | csb held high for CS_HIGH_CYCLES, starting with the ack cycle
module flash_read_arbiter
  import flash_arb_pkg::*;
#(
  parameter int CLK_DIV        = 2,
  parameter int CS_HIGH_CYCLES = 4,
  parameter int ADDR_BITS      = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  flash_read_arbiter_if.slave  bus,
  output logic                 flash_csb,
  output logic                 flash_clk,
  output logic                 flash_mosi,
  input  logic                 flash_miso,
  output logic                 busy,
  output logic                 owner
);
  localparam int GAP_W = $clog2(CS_HIGH_CYCLES + 1);
  localparam logic [23:0] ADDR_MASK = 24'hFFFFFC;

  arb_state_e           state, state_nxt;
  logic                 prio;
  logic                 grant_port;
  logic                 start;
  logic                 done;
  logic [GAP_W-1:0]     gap_cnt;
  logic [ADDR_BITS-1:0] addr_sel;
  logic [XFER_BITS-1:0] frame;
  logic [DATA_BITS-1:0] rx_word;
  logic [DATA_BITS-1:0] rx_le;

  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    grant_port = prio;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          start      = 1'b1;
          state_nxt  = SHIFT;
          grant_port = (bus.req0 && bus.req1) ? prio : bus.req1;
        end
      end
      SHIFT:   if (done) state_nxt = GAP;
      GAP:     if (gap_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign addr_sel = grant_port ? bus.addr1 : bus.addr0;
  assign frame    = {FLASH_CMD_READ, 24'(addr_sel) & ADDR_MASK, {DATA_BITS{1'b0}}};
  // First flash byte received lands in the low byte.
  assign rx_le    = {rx_word[7:0], rx_word[15:8], rx_word[23:16], rx_word[31:24]};

  assign flash_csb = (state != SHIFT);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      prio       <= 1'b0;
      owner      <= 1'b0;
      gap_cnt    <= '0;
      bus.ack0   <= 1'b0;
      bus.ack1   <= 1'b0;
      bus.rdata0 <= '0;
      bus.rdata1 <= '0;
    end else begin
      bus.ack0 <= 1'b0;
      bus.ack1 <= 1'b0;
      if (start) begin
        owner <= grant_port;
        prio  <= ~grant_port;
      end
      if (state == SHIFT && done) begin
        gap_cnt <= GAP_W'(CS_HIGH_CYCLES - 1);
        // A requester that withdrew mid-frame gets no ack and keeps its old data.
        if (!owner && bus.req0) begin
          bus.ack0   <= 1'b1;
          bus.rdata0 <= rx_le;
        end
        if (owner && bus.req1) begin
          bus.ack1   <= 1'b1;
          bus.rdata1 <= rx_le;
        end
      end else if (state == GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

  spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .load       (start),
    .load_frame (frame),
    .run        (state == SHIFT),
    .miso       (flash_miso),
    .sck        (flash_clk),
    .mosi       (flash_mosi),
    .done       (done),
    .rx_word    (rx_word)
  );
endmodule

// File: tb/tb_flash_read_arbiter.sv
// Directed bench for flash_read_arbiter with a mode-0 READ flash model where byte n = n[7:0].
module tb_flash_read_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flash_csb, flash_clk, flash_mosi, busy, owner;
  logic flash_miso = 1'b0;

  flash_read_arbiter_if #(.ADDR_BITS(24)) bus ();

  flash_read_arbiter #(.CLK_DIV(2), .CS_HIGH_CYCLES(4), .ADDR_BITS(24)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .flash_csb  (flash_csb),
    .flash_clk  (flash_clk),
    .flash_mosi (flash_mosi),
    .flash_miso (flash_miso),
    .busy       (busy),
    .owner      (owner)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Flash model: count SCK rises, collect command/address, drive data on falling edges.
  int          rise_cnt;
  logic [31:0] cmd_word;

  always @(posedge flash_clk or negedge flash_csb) begin
    if (!flash_clk) begin
      rise_cnt <= 0;
      cmd_word <= '0;
    end else if (!flash_csb) begin
      if (rise_cnt < 32) cmd_word <= {cmd_word[30:0], flash_mosi};
      rise_cnt <= rise_cnt + 1;
    end
  end

  function automatic logic data_bit(input logic [7:0] base, input int d);
    logic [7:0] b;
    b = base + 8'(d / 8);
    return b[7 - (d % 8)];
  endfunction

  always @(negedge flash_clk) begin
    if (!flash_csb && rise_cnt >= 32 && rise_cnt < 64)
      flash_miso <= data_bit(cmd_word[7:0], rise_cnt - 32);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic port, input logic val, input logic [23:0] addr);
    if (port) begin
      bus.req1  = val;
      bus.addr1 = addr;
    end else begin
      bus.req0  = val;
      bus.addr0 = addr;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && busy; i++) step();
    check("idle_reached", {63'd0, busy}, 64'd0);
  endtask

  // Caller must be in an IDLE cycle; that cycle becomes cycle 0.
  task automatic run_single(input logic port, input logic [23:0] addr,
                            output int ack_rel, output logic [31:0] data,
                            output logic other_ack, output logic c1_low,
                            output int rises, output logic [31:0] mosi_hi);
    ack_rel   = -1;
    data      = '0;
    other_ack = 1'b0;
    c1_low    = 1'b0;
    rises     = 0;
    mosi_hi   = '0;
    set_req(port, 1'b1, addr);
    for (int i = 1; i <= 400 && ack_rel < 0; i++) begin
      step();
      if (i == 1) c1_low = !flash_csb;
      if (port ? bus.ack0 : bus.ack1) other_ack = 1'b1;
      if (port ? bus.ack1 : bus.ack0) begin
        ack_rel = i;
        data    = port ? bus.rdata1 : bus.rdata0;
        rises   = rise_cnt;
        mosi_hi = cmd_word;
        set_req(port, 1'b0, addr);
      end
    end
    set_req(port, 1'b0, addr);
    wait_idle();
  endtask

  typedef struct {
    logic        port;
    logic [23:0] addr;
    logic [31:0] exp_data;
    logic [31:0] exp_mosi;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int          ack_rel, rises;
    logic [31:0] data, mosi_hi, rd0, rd1;
    logic        other_ack, c1_low;

    vecs[0] = '{1'b0, 24'h000100, 32'h03020100, 32'h03000100};
    vecs[1] = '{1'b0, 24'h000103, 32'h03020100, 32'h03000100};
    vecs[2] = '{1'b1, 24'h000010, 32'h13121110, 32'h03000010};
    vecs[3] = '{1'b0, 24'h0000FC, 32'hFFFEFDFC, 32'h030000FC};
    vecs[4] = '{1'b1, 24'hABCDE6, 32'hE7E6E5E4, 32'h03ABCDE4};
    vecs[5] = '{1'b1, 24'hFFFFFE, 32'hFFFEFDFC, 32'h03FFFFFC};

    bus.req0 = 1'b0; bus.addr0 = '0;
    bus.req1 = 1'b0; bus.addr1 = '0;
    repeat (3) step();
    check("rst_csb",   {63'd0, flash_csb}, 64'd1);
    check("rst_sck",   {63'd0, flash_clk}, 64'd0);
    check("rst_mosi",  {63'd0, flash_mosi}, 64'd0);
    check("rst_acks",  {62'd0, bus.ack1, bus.ack0}, 64'd0);
    check("rst_rdata", {bus.rdata1, bus.rdata0}, 64'd0);
    check("rst_busy_owner", {62'd0, busy, owner}, 64'd0);
    rst = 1'b0;
    step();
    rd0 = '0;
    rd1 = '0;

    // Single-port reads
    for (int v = 0; v < 6; v++) begin
      run_single(vecs[v].port, vecs[v].addr, ack_rel, data, other_ack, c1_low, rises, mosi_hi);
      check($sformatf("v%0d_ack_cycle", v), 64'(ack_rel), 64'd257);
      check($sformatf("v%0d_rdata", v), {32'd0, data}, {32'd0, vecs[v].exp_data});
      check($sformatf("v%0d_mosi", v), {32'd0, mosi_hi}, {32'd0, vecs[v].exp_mosi});
      check($sformatf("v%0d_rises", v), 64'(rises), 64'd64);
      check($sformatf("v%0d_csb_c1", v), {63'd0, c1_low}, 64'd1);
      check($sformatf("v%0d_other_ack", v), {63'd0, other_ack}, 64'd0);
      if (vecs[v].port) rd1 = vecs[v].exp_data;
      else              rd0 = vecs[v].exp_data;
      check($sformatf("v%0d_other_rdata", v),
            {32'd0, vecs[v].port ? bus.rdata0 : bus.rdata1},
            {32'd0, vecs[v].port ? rd0 : rd1});
    end

    // Simultaneous requests: port 0 first, then port 1 after the csb-high gap
    begin
      int a0, a1, high_cnt;
      logic [31:0] d0, d1;
      logic own262;
      a0 = -1; a1 = -1; high_cnt = 0; d0 = '0; d1 = '0; own262 = 1'b0;
      set_req(1'b0, 1'b1, 24'h000100);
      set_req(1'b1, 1'b1, 24'h000010);
      for (int i = 1; i <= 700 && a1 < 0; i++) begin
        step();
        if (i == 262) own262 = owner;
        if (bus.ack0) begin
          a0 = i; d0 = bus.rdata0; bus.req0 = 1'b0;
        end
        if (bus.ack1) begin
          a1 = i; d1 = bus.rdata1; bus.req1 = 1'b0;
        end else if (a0 >= 0 && flash_csb) begin
          high_cnt++;
        end
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      check("tie_ack0_cycle", 64'(a0), 64'd257);
      check("tie_rdata0", {32'd0, d0}, 64'h03020100);
      check("tie_ack1_cycle", 64'(a1), 64'd518);
      check("tie_rdata1", {32'd0, d1}, 64'h13121110);
      check("tie_csb_high_gap", 64'(high_cnt), 64'd5);
      check("tie_owner_262", {63'd0, own262}, 64'd1);
      wait_idle();
    end

    // Both ports continuously re-requesting alternate
    begin
      int order[4];
      logic [31:0] dat[4];
      int exp_order[4];
      logic [31:0] exp_dat[4];
      int n;
      logic re0, re1;
      exp_order = '{0, 1, 0, 1};
      exp_dat   = '{32'h03020100, 32'h07060504, 32'h03020100, 32'h07060504};
      for (int k = 0; k < 4; k++) begin
        order[k] = -1;
        dat[k]   = '0;
      end
      n = 0; re0 = 1'b0; re1 = 1'b0;
      set_req(1'b0, 1'b1, 24'h000200);
      set_req(1'b1, 1'b1, 24'h000304);
      for (int i = 1; i <= 2000 && n < 4; i++) begin
        step();
        if (re0) begin bus.req0 = 1'b1; re0 = 1'b0; end
        if (re1) begin bus.req1 = 1'b1; re1 = 1'b0; end
        if (bus.ack0 && n < 4) begin
          order[n] = 0; dat[n] = bus.rdata0; n++; bus.req0 = 1'b0; re0 = 1'b1;
        end
        if (bus.ack1 && n < 4) begin
          order[n] = 1; dat[n] = bus.rdata1; n++; bus.req1 = 1'b0; re1 = 1'b1;
        end
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      for (int k = 0; k < 4; k++) begin
        check($sformatf("rr_order%0d", k), 64'(order[k]), 64'(exp_order[k]));
        check($sformatf("rr_data%0d", k), {32'd0, dat[k]}, {32'd0, exp_dat[k]});
      end
      rd0 = 32'h03020100;
      rd1 = 32'h07060504;
      wait_idle();
    end

    // Port 1 withdraws mid-frame: no ack, data kept, frame still finishes
    begin
      logic any_ack, csb257;
      any_ack = 1'b0; csb257 = 1'b0;
      set_req(1'b1, 1'b1, 24'h000040);
      for (int i = 1; i <= 300; i++) begin
        step();
        if (i == 100) bus.req1 = 1'b0;
        if (bus.ack0 || bus.ack1) any_ack = 1'b1;
        if (i == 257) csb257 = flash_csb;
      end
      check("drop_no_ack", {63'd0, any_ack}, 64'd0);
      check("drop_csb257", {63'd0, csb257}, 64'd1);
      check("drop_rdata1_kept", {32'd0, bus.rdata1}, {32'd0, rd1});
      check("drop_idle", {63'd0, busy}, 64'd0);
      run_single(1'b0, 24'h000080, ack_rel, data, other_ack, c1_low, rises, mosi_hi);
      check("after_drop_ack_cycle", 64'(ack_rel), 64'd257);
      check("after_drop_rdata0", {32'd0, data}, 64'h83828180);
    end

    // Reset mid-transaction
    begin
      int sck_hi;
      sck_hi = 0;
      set_req(1'b0, 1'b1, 24'h000100);
      for (int i = 1; i <= 150; i++) step();
      check("mid_csb_low", {63'd0, flash_csb}, 64'd0);
      rst = 1'b1;
      bus.req0 = 1'b0;
      step();
      check("rst_mid_csb", {63'd0, flash_csb}, 64'd1);
      check("rst_mid_sck", {63'd0, flash_clk}, 64'd0);
      check("rst_mid_busy", {63'd0, busy}, 64'd0);
      check("rst_mid_acks_owner", {61'd0, bus.ack1, bus.ack0, owner}, 64'd0);
      check("rst_mid_rdata", {bus.rdata1, bus.rdata0}, 64'd0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
        step();
        if (flash_clk) sck_hi++;
      end
      check("rst_no_sck_pulse", 64'(sck_hi), 64'd0);
      run_single(1'b0, 24'h000044, ack_rel, data, other_ack, c1_low, rises, mosi_hi);
      check("post_rst_ack_cycle", 64'(ack_rel), 64'd257);
      check("post_rst_rdata0", {32'd0, data}, 64'h47464544);
      check("post_rst_rises", 64'(rises), 64'd64);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
